snake_pixel_renderer: RTL and testbench

Pixel-colour stage directly downstream of the VGA timing generator. Consumes the generator's `x`, `y` and `display` outputs and produces 12-bit RGB for the monitor from a 40×30 game-cell map held in internal storage (16×16 pixels per cell). Game logic writes individual cells through a valid/ready port. The block also emits a once-per-frame tick that paces the game's update logic.

---
 rtl/snake_pixel_renderer.sv | 130 +++++++++++++
 tb/tb_snake_pixel_renderer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_pixel_renderer.sv
// snake_pixel_renderer: colours VGA scan positions from a 40x30 game-cell map and paces the game with a frame tick
//
// Ports:
//   clk, rst_n                    system clock; asynchronous active-low reset
//   x_i, y_i, display_i           scan column/row and visible-region flag from the timing generator
//   cell_wr_valid_i/ready_o       single-cell write handshake (accepted on valid && ready)
//   cell_x_i, cell_y_i, cell_val_i  target cell and its type (0 empty, 1 body, 2 head, 3 food)
//   clr_req_i, clr_done_o         whole-map clear request and one-cycle completion pulse
//   rgb_o                         {R,G,B} colour, two clk behind the x_i/display_i sample
//   frame_tick_o                  one-clk pulse when y_i steps from 479 to 480
//   wr_err_o                      sticky flag: an out-of-range write was accepted
module snake_pixel_renderer #(
    parameter int CELL_SHIFT = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic        display_i,
    input  logic        cell_wr_valid_i,
    output logic        cell_wr_ready_o,
    input  logic [5:0]  cell_x_i,
    input  logic [4:0]  cell_y_i,
    input  logic [1:0]  cell_val_i,
    input  logic        clr_req_i,
    output logic        clr_done_o,
    output logic [11:0] rgb_o,
    output logic        frame_tick_o,
    output logic        wr_err_o
);
    localparam int LINE_W = 2 * GRID_W;
    localparam int H_VIS  = GRID_W << CELL_SHIFT;
    localparam int V_VIS  = GRID_H << CELL_SHIFT;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    logic [LINE_W-1:0] mem_q [GRID_H];
    logic [LINE_W-1:0] line_q, line_d;
    logic [0:0]        state_q, state_d;
    logic [4:0]        row_q, row_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_err_q, wr_err_d;
    logic [9:0]        x_prev_q, y_prev_q;
    logic [5:0]        s1_cell_q;
    logic              s1_disp_q;
    logic [11:0]       rgb_q, rgb_d;
    logic              fetch, clr_step, wr_acc, wr_in_range;
    logic [10:0]       y_next;
    logic [4:0]        fetch_row;
    logic [1:0]        pix_cell;

    // One fetch per line: only the first clk of x == 640 counts, since x holds for 2 clk.
    assign fetch       = (x_i == 10'(H_VIS)) && (x_prev_q != 10'(H_VIS));
    // The fetch at the end of line y loads the row for line y+1; wrap to row 0 past the last visible line.
    assign y_next      = {1'b0, y_i} + 11'd1;
    assign fetch_row   = (y_next < 11'(V_VIS)) ? 5'(y_next >> CELL_SHIFT) : 5'd0;
    assign clr_step    = (state_q == S_CLEAR) && !fetch;
    assign wr_in_range = (cell_x_i < 6'(GRID_W)) && (cell_y_i < 5'(GRID_H));
    assign wr_acc      = cell_wr_valid_i && cell_wr_ready_o;

    assign cell_wr_ready_o = (state_q == S_IDLE) && !fetch;
    assign clr_done_o      = clr_done_q;
    assign wr_err_o        = wr_err_q;
    assign rgb_o           = rgb_q;
    assign frame_tick_o    = (y_i == 10'(V_VIS)) && (y_prev_q == 10'(V_VIS - 1));

    assign line_d   = fetch ? mem_q[fetch_row] : line_q;
    assign wr_err_d = wr_err_q | (wr_acc & ~wr_in_range);
    assign pix_cell = 2'(line_q >> {s1_cell_q, 1'b0});
    assign rgb_d    = !s1_disp_q         ? 12'h000 :
                      pix_cell == 2'd1   ? 12'h0F0 :
                      pix_cell == 2'd2   ? 12'hFF0 :
                      pix_cell == 2'd3   ? 12'hF00 : 12'h000;

    // Clear walks rows 0..GRID_H-1, pausing on fetch cycles; clr_req is only honoured from IDLE.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        clr_done_d = 1'b0;
        if (state_q == S_CLEAR) begin
            if (!fetch) begin
                row_d = row_q + 5'd1;
                if (row_q == 5'(GRID_H - 1)) begin
                    state_d    = S_IDLE;
                    row_d      = '0;
                    clr_done_d = 1'b1;
                end
            end
        end else if (clr_req_i) begin
            state_d = S_CLEAR;
            row_d   = '0;
        end
    end

    // Map storage carries no reset; the post-reset clear zeroes it.
    always_ff @(posedge clk) begin
        if (clr_step)
            mem_q[row_q] <= '0;
        else if (wr_acc && wr_in_range)
            mem_q[cell_y_i][{cell_x_i, 1'b0} +: 2] <= cell_val_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            row_q      <= '0;
            clr_done_q <= 1'b0;
            wr_err_q   <= 1'b0;
            x_prev_q   <= '0;
            y_prev_q   <= '0;
            line_q     <= '0;
            s1_cell_q  <= '0;
            s1_disp_q  <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            clr_done_q <= clr_done_d;
            wr_err_q   <= wr_err_d;
            x_prev_q   <= x_i;
            y_prev_q   <= y_i;
            line_q     <= line_d;
            s1_cell_q  <= 6'(x_i >> CELL_SHIFT);
            s1_disp_q  <= display_i;
            rgb_q      <= rgb_d;
        end
    end
endmodule

// File: tb/tb_snake_pixel_renderer.sv
// tb_snake_pixel_renderer: table vectors, hand sequences and randomized frames against a cell-level reference model
module tb_snake_pixel_renderer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        disp = 1'b0;
    logic        wv = 1'b0;
    logic [5:0]  cx = '0;
    logic [4:0]  cy = '0;
    logic [1:0]  cv = '0;
    logic        clr = 1'b0;
    logic        ready, done, ftick, err;
    logic [11:0] rgb;
    int total = 0;
    int bad = 0;
    bit rnd_on = 0;
    int ft_cnt = 0;
    int lit_cnt = 0;

    always #5 clk = ~clk;

    snake_pixel_renderer dut (
        .clk(clk), .rst_n(rst_n), .x_i(x), .y_i(y), .display_i(disp),
        .cell_wr_valid_i(wv), .cell_wr_ready_o(ready), .cell_x_i(cx), .cell_y_i(cy),
        .cell_val_i(cv), .clr_req_i(clr), .clr_done_o(done), .rgb_o(rgb),
        .frame_tick_o(ftick), .wr_err_o(err)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int colour(input int v);
        case (v)
            1: return 'h0F0;
            2: return 'hFF0;
            3: return 'hF00;
            default: return 'h000;
        endcase
    endfunction

    // Reference model: the map as a 30x40 array of cell types, the displayed line as a copy of one row,
    // a count of rows still to clear, and the two-clk colour pipeline.
    int m_mem [30][40];
    int m_line [40];
    int m_clear_left;
    bit m_done, m_err, m_s1_disp;
    int m_xprev, m_yprev, m_s1_cell, m_rgb;

    always @(negedge clk) begin
        bit f;
        int row;
        if (!rst_n) begin
            check("rst_rgb", rgb, 0);
            check("rst_ready", ready, 0);
            check("rst_clr_done", done, 0);
            check("rst_wr_err", err, 0);
            m_clear_left = 30;
            m_done = 0;
            m_err = 0;
            m_xprev = 0;
            m_yprev = 0;
            m_s1_cell = 0;
            m_s1_disp = 0;
            m_rgb = 0;
            foreach (m_line[i]) m_line[i] = 0;
        end else begin
            f = (x == 640) && (m_xprev != 640);
            check("ready", ready, int'((m_clear_left == 0) && !f));
            check("frame_tick", ftick, int'((y == 480) && (m_yprev == 479)));
            check("clr_done", done, m_done);
            check("wr_err", err, m_err);
            check("rgb", rgb, m_rgb);
            if (ftick) ft_cnt++;
            if (rgb != 0) lit_cnt++;
            m_rgb = m_s1_disp ? colour(m_s1_cell < 40 ? m_line[m_s1_cell] : 0) : 0;
            m_s1_cell = x / 16;
            m_s1_disp = disp;
            m_done = 0;
            if (f) begin
                row = (y + 1 < 480) ? (y + 1) / 16 : 0;
                m_line = m_mem[row];
            end
            if (m_clear_left > 0) begin
                if (!f) begin
                    m_mem[30 - m_clear_left] = '{default: 0};
                    m_clear_left--;
                    m_done = (m_clear_left == 0);
                end
            end else begin
                if (wv && !f) begin
                    if (cx < 40 && cy < 30) m_mem[cy][cx] = cv;
                    else m_err = 1;
                end
                if (clr) m_clear_left = 30;
            end
            m_xprev = x;
            m_yprev = y;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One timing-generator pixel lasts 2 clk.
    task automatic pix(input int px, input int py, input bit d);
        x = 10'(px);
        y = 10'(py);
        disp = d;
        for (int i = 0; i < 2; i++) begin
            if (rnd_on) begin
                wv = ($urandom_range(3) == 0);
                cx = 6'($urandom_range(42));
                cy = 5'($urandom_range(31));
                cv = 2'($urandom);
                clr = ($urandom_range(600) == 0);
            end
            tick();
        end
    endtask

    task automatic wr(input int wx, input int wy, input int wval);
        bit acc = 0;
        x = 700;
        wv = 1;
        cx = 6'(wx);
        cy = 5'(wy);
        cv = 2'(wval);
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            acc = ready;
            tick();
        end
        wv = 0;
        if (!acc) check("wr_timeout", 0, 1);
    endtask

    task automatic probe(input string nm, input int px, input int py, input int exp);
        pix(640, (py == 0) ? 524 : py - 1, 0);
        x = 10'(px);
        y = 10'(py);
        disp = 1;
        tick();
        tick();
        disp = 0;
        @(negedge clk);
        check(nm, rgb, exp);
        tick();
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int c = 0; c < limit && cyc < 0; c++) begin
            @(negedge clk);
            if (done) cyc = c;
            tick();
        end
    endtask

    // Compressed frame: each cell row is shown on one line, preceded by the fetch at the end of the line above.
    task automatic frame();
        ft_cnt = 0;
        lit_cnt = 0;
        for (int r = 0; r < 30; r++) begin
            int yy = 16 * r + $urandom_range(15);
            int yp = (yy == 0) ? 524 : yy - 1;
            pix(640, yp, 0);
            pix(760, yp, 0);
            for (int c = 0; c < 40; c++) pix(16 * c + $urandom_range(15), yy, 1);
            pix(650, yy, 0);
        end
        pix(640, 479, 0);
        pix(0, 480, 0);
        pix(640, 480, 0);
        pix(100, 500, 0);
        pix(640, 524, 0);
        pix(0, 0, 0);
    endtask

    typedef struct { int wx, wy, val, err, px, py, rgb; } vec_t;
    vec_t tbl [14];

    initial begin
        int first, pulses, r32, r33, cyc, ra, rb;
        tbl[0]  = '{5, 2, 2, 0, 80, 32, 'hFF0};
        tbl[1]  = '{5, 2, 2, 0, 95, 47, 'hFF0};
        tbl[2]  = '{0, 0, 0, 0, 79, 40, 'h000};
        tbl[3]  = '{39, 29, 3, 0, 639, 479, 'hF00};
        tbl[4]  = '{39, 29, 3, 0, 624, 464, 'hF00};
        tbl[5]  = '{40, 0, 1, 1, 0, 0, 'h000};
        tbl[6]  = '{0, 30, 1, 1, 0, 479, 'h000};
        tbl[7]  = '{1, 0, 1, 1, 16, 0, 'h0F0};
        tbl[8]  = '{1, 0, 0, 1, 31, 15, 'h000};
        tbl[9]  = '{10, 15, 2, 1, 160, 240, 'hFF0};
        tbl[10] = '{63, 31, 3, 1, 90, 40, 'hFF0};
        tbl[11] = '{6, 2, 3, 1, 96, 32, 'hF00};
        tbl[12] = '{4, 2, 1, 1, 79, 47, 'h0F0};
        tbl[13] = '{4, 2, 1, 1, 85, 40, 'hFF0};

        #1 rst_n = 0;
        y = 100;
        repeat (3) tick();
        // Reset release with fetches at cycles 3, 10 and 20 (x holds 640 for 2 clk): clear ends in cycle 33.
        rst_n = 1;
        first = -1;
        pulses = 0;
        r32 = -1;
        r33 = -1;
        for (int c = 0; c < 60; c++) begin
            x = (c == 3 || c == 4 || c == 10 || c == 11 || c == 20 || c == 21) ? 10'd640 : 10'd0;
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (c == 32) r32 = ready;
            if (c == 33) r33 = ready;
            tick();
        end
        check("reset_clr_done_cycle", first, 33);
        check("reset_clr_done_pulses", pulses, 1);
        check("reset_ready_before_done", r32, 0);
        check("reset_ready_at_done", r33, 1);

        frame();
        check("blank_frame_lit", lit_cnt, 0);
        check("blank_frame_ticks", ft_cnt, 1);

        foreach (tbl[i]) begin
            wr(tbl[i].wx, tbl[i].wy, tbl[i].val);
            @(negedge clk);
            check($sformatf("tbl%0d_wr_err", i), err, tbl[i].err);
            tick();
            probe($sformatf("tbl%0d_rgb", i), tbl[i].px, tbl[i].py, tbl[i].rgb);
        end

        // Write held across the fetch at the end of line 40, targeting row 2 which is on screen.
        pix(640, 39, 0);
        pix(200, 40, 0);
        x = 640;
        y = 40;
        wv = 1;
        cx = 7;
        cy = 2;
        cv = 3;
        @(negedge clk);
        ra = ready;
        tick();
        @(negedge clk);
        rb = ready;
        tick();
        wv = 0;
        check("hold_ready_fetch", ra, 0);
        check("hold_ready_next", rb, 1);
        x = 117;
        y = 41;
        disp = 1;
        tick();
        tick();
        disp = 0;
        @(negedge clk);
        check("hold_no_tear", rgb, 'h000);
        tick();
        pix(640, 41, 0);
        x = 117;
        y = 42;
        disp = 1;
        tick();
        tick();
        disp = 0;
        @(negedge clk);
        check("hold_next_line", rgb, 'hF00);
        tick();

        rnd_on = 1;
        for (int f = 0; f < 6; f++) begin
            frame();
            check($sformatf("rand_frame%0d_ticks", f), ft_cnt, 1);
        end
        rnd_on = 0;
        wv = 0;
        clr = 0;
        for (int i = 0; i < 25; i++) pix(700, 500, 0);

        // Clear request at cycle 0, a second ignored request at cycle 10: done in cycle 31.
        wr(3, 3, 2);
        wr(20, 10, 1);
        x = 700;
        first = -1;
        for (int c = 0; c < 80 && first < 0; c++) begin
            clr = (c == 0 || c == 10);
            @(negedge clk);
            if (done) first = c;
            tick();
        end
        clr = 0;
        check("clr_req_done_cycle", first, 31);
        frame();
        check("post_clear_frame_lit", lit_cnt, 0);
        check("post_clear_frame_ticks", ft_cnt, 1);

        // Reset in the middle of a clear restarts it from row 0.
        wr(50, 1, 1);
        wr(8, 8, 3);
        clr = 1;
        tick();
        clr = 0;
        repeat (10) tick();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        wait_done(80, cyc);
        check("midclear_reset_done_cycle", cyc, 30);
        @(negedge clk);
        check("midclear_reset_wr_err", err, 0);
        tick();
        frame();
        check("after_reset_frame_lit", lit_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
